game_sched: RTL

- Game-flow controller for the falling-slime game.
- Sequences the floor generator and the slime mover through start, play, pause, dying and game-over phases.
- Owns HP, score and the floor-scroll period (time_gap); issues a clear pulse and run enable to both datapath blocks.
- Sits in the top level between the keyboard one-pulse logic and floor_gen/slime_move; its outputs also feed pixel_gen for HUD display.

---
 rtl/game_pkg.sv | 21 ++
 rtl/hp_unit.sv | 73 +++++++
 rtl/game_sched.sv | 130 +++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared encodings and widths for the falling-slime game-flow controller.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    PLAY  = 3'd2,
    PAUSE = 3'd3,
    DYING = 3'd4,
    OVER  = 3'd5
  } state_t;

  localparam int GAP_W   = 9;
  localparam int HP_W    = 4;
  localparam int SCORE_W = 10;
  localparam int LEVEL_W = 4;

  localparam logic [SCORE_W-1:0] SCORE_MAX = 10'd999;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 4'd15;

endpackage

// File: rtl/hp_unit.sv
// Hit-point keeper: owns hp and the post-hit invulnerability countdown.
module hp_unit
  import game_pkg::*;
#(
  parameter int HP_MAX    = 10,
  parameter int HIT_DMG   = 3,
  parameter int INV_TICKS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            land,
  input  logic            hit,
  input  logic            tick,
  input  logic            freeze,
  input  logic            kill,
  output logic [HP_W-1:0] hp,
  output logic            hp_zero
);

  localparam int INV_W = $clog2(INV_TICKS + 1);

  logic [INV_W-1:0]     inv_cnt;
  logic [INV_W-1:0]     inv_nxt;
  logic [HP_W-1:0]      hp_nxt;
  logic signed [HP_W:0] hp_sum;
  logic                 hit_eff;

  // hp_zero reflects the value hp is about to take, so the FSM can leave
  // PLAY on the same edge that hp reaches zero.
  always_comb begin
    hit_eff = hit && (inv_cnt == '0);
    hp_sum  = $signed({1'b0, hp}) + $signed({{HP_W{1'b0}}, land});
    if (hit_eff) hp_sum = hp_sum - $signed((HP_W + 1)'(HIT_DMG));

    if (hp_sum < 0)
      hp_nxt = '0;
    else if (hp_sum > $signed((HP_W + 1)'(HP_MAX)))
      hp_nxt = HP_W'(HP_MAX);
    else
      hp_nxt = hp_sum[HP_W-1:0];

    if (hit_eff)
      inv_nxt = INV_W'(INV_TICKS);
    else if (tick && (inv_cnt != '0))
      inv_nxt = inv_cnt - INV_W'(1);
    else
      inv_nxt = inv_cnt;

    if (kill) hp_nxt = '0;

    if (load) begin
      hp_nxt  = HP_W'(HP_MAX);
      inv_nxt = '0;
    end else if (freeze) begin
      hp_nxt  = hp;
      inv_nxt = inv_cnt;
    end

    hp_zero = (hp_nxt == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hp      <= HP_W'(HP_MAX);
      inv_cnt <= '0;
    end else begin
      hp      <= hp_nxt;
      inv_cnt <= inv_nxt;
    end
  end

endmodule

// File: rtl/game_sched.sv
// Game-flow controller: sequences start/play/pause/dying/over and keeps
// score, level and the floor-scroll period for the datapath and HUD.
module game_sched
  import game_pkg::*;
#(
  parameter int               HP_MAX       = 10,
  parameter int               HIT_DMG      = 3,
  parameter int               INV_TICKS    = 32,
  parameter logic [GAP_W-1:0] GAP_INIT     = 9'd200,
  parameter logic [GAP_W-1:0] GAP_MIN      = 9'd40,
  parameter logic [GAP_W-1:0] GAP_STEP     = 9'd10,
  parameter int               LEVEL_FLOORS = 10,
  parameter int               DIE_TICKS    = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               key_start,
  input  logic               key_pause,
  input  logic               hit_ceiling,
  input  logic               land,
  input  logic               fell,
  output logic [2:0]         state,
  output logic               run_en,
  output logic               game_clr,
  output logic [GAP_W-1:0]   time_gap,
  output logic [HP_W-1:0]    hp,
  output logic [SCORE_W-1:0] score,
  output logic [LEVEL_W-1:0] level
);

  localparam int FLOOR_W = $clog2(LEVEL_FLOORS);
  localparam int DIE_W   = $clog2(DIE_TICKS + 1);
  localparam logic [FLOOR_W-1:0] FLOOR_LAST = FLOOR_W'(LEVEL_FLOORS - 1);

  state_t             cur;
  state_t             nxt;
  logic [FLOOR_W-1:0] floor_cnt;
  logic [DIE_W-1:0]   die_cnt;
  logic               hp_zero;
  logic               in_play;
  logic               land_ok;

  assign state   = cur;
  assign run_en  = (cur == PLAY);
  assign in_play = (cur == PLAY);
  assign land_ok = in_play && !fell && land;

  hp_unit #(
    .HP_MAX   (HP_MAX),
    .HIT_DMG  (HIT_DMG),
    .INV_TICKS(INV_TICKS)
  ) u_hp (
    .clk    (clk),
    .rst    (rst),
    .load   (cur == INIT),
    .land   (land),
    .hit    (hit_ceiling),
    .tick   (tick),
    .freeze (!in_play),
    .kill   (in_play && fell),
    .hp     (hp),
    .hp_zero(hp_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cur <= IDLE;
    else      cur <= nxt;
  end

  // A fall forces hp to zero inside hp_unit, so hp_zero alone covers both
  // ways of dying and already outranks a same-cycle pause request.
  always_comb begin
    nxt = cur;
    case (cur)
      IDLE:  if (key_start) nxt = INIT;
      INIT:  nxt = PLAY;
      PLAY: begin
        if (hp_zero)        nxt = DYING;
        else if (key_pause) nxt = PAUSE;
      end
      PAUSE: if (key_pause) nxt = PLAY;
      DYING: if (tick && (die_cnt == DIE_W'(1))) nxt = OVER;
      OVER:  if (key_start) nxt = INIT;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      game_clr  <= 1'b0;
      time_gap  <= GAP_INIT;
      score     <= '0;
      level     <= '0;
      floor_cnt <= '0;
      die_cnt   <= '0;
    end else begin
      game_clr <= (nxt == INIT);
      case (cur)
        INIT: begin
          time_gap  <= GAP_INIT;
          score     <= '0;
          level     <= '0;
          floor_cnt <= '0;
          die_cnt   <= '0;
        end
        PLAY: begin
          if (land_ok) begin
            if (score != SCORE_MAX) score <= score + SCORE_W'(1);
            if (floor_cnt == FLOOR_LAST) begin
              floor_cnt <= '0;
              if (level != LEVEL_MAX) level <= level + LEVEL_W'(1);
              // Compare before subtracting so the 9-bit period never wraps.
              if ({1'b0, time_gap} >= ({1'b0, GAP_MIN} + {1'b0, GAP_STEP}))
                time_gap <= time_gap - GAP_STEP;
              else
                time_gap <= GAP_MIN;
            end else begin
              floor_cnt <= floor_cnt + FLOOR_W'(1);
            end
          end
          if (nxt == DYING) die_cnt <= DIE_W'(DIE_TICKS);
        end
        DYING: if (tick && (die_cnt != '0)) die_cnt <= die_cnt - DIE_W'(1);
        default: ;
      endcase
    end
  end

endmodule
